// File: rtl/main_mem_responder.sv
// Backing-memory responder for the data cache: accepts one line read or one
// single-word write at a time and answers after a fixed latency.
module main_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int MEM_SIZE   = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [$clog2(MEM_SIZE)-1:0]   req_addr,
  input  logic [WIDTH-1:0]              req_wdata,
  output logic                          rsp_valid,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [$clog2(LINE_WORDS)-1:0] rsp_offset,
  output logic                          rsp_last,
  output logic                          wr_done,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so the
  // requester holds req_valid and its payload until that edge.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WDONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     lat_q, lat_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  mem_q [MEM_SIZE];

  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [OW-1:0]     rsp_offset_q, rsp_offset_d;
  logic              rsp_last_q, rsp_last_d;
  logic              wr_done_q, wr_done_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          beat_d  = '0;
          if (LATENCY == 1) begin
            state_d = req_write ? S_WDONE : S_BURST;
          end else begin
            state_d = S_WAIT;
            lat_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (lat_q == CW'(1)) state_d = wr_q ? S_WDONE : S_BURST;
        else                 lat_d   = lat_q - CW'(1);
      end
      S_BURST: begin
        if (beat_q == OW'(LINE_WORDS - 1)) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + OW'(1);
        end
      end
      S_WDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so a beat's data is read
  // from the array one edge early; no write can land during a burst.
  always_comb begin
    rsp_valid_d  = (state_d == S_BURST);
    rsp_offset_d = rsp_valid_d ? beat_d : '0;
    rsp_last_d   = rsp_valid_d && (beat_d == OW'(LINE_WORDS - 1));
    rsp_data_d   = rsp_valid_d ? mem_q[{addr_d[AW-1:OW], beat_d}] : '0;
    wr_done_d    = (state_d == S_WDONE);
    busy_d       = (state_d != S_IDLE);
    req_ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      beat_q       <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_offset_q <= '0;
      rsp_last_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      beat_q       <= beat_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_offset_q <= rsp_offset_d;
      rsp_last_q   <= rsp_last_d;
      wr_done_q    <= wr_done_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
      if (state_q == S_WDONE) mem_q[addr_q] <= wdata_q;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_offset = rsp_offset_q;
  assign rsp_last   = rsp_last_q;
  assign wr_done    = wr_done_q;
  assign busy       = busy_q;
  assign req_ready  = req_ready_q;
  assign dbg_state  = state_q;

endmodule
